// File: rtl/div_unit32.sv
// -----------------------------------------------------------------------------
// div_unit32 -- multi-cycle signed/unsigned integer divider (restoring,
// one quotient bit per clock) for the execute stage (DIV/DIVU).
//
// Ports
//   clk        in   1     rising-edge clock
//   rst        in   1     asynchronous, active-high reset
//   start      in   1     request; sampled only while busy=0
//   is_signed  in   1     1 = two's-complement divide, 0 = unsigned
//   a          in   XLEN  dividend, captured with start
//   b          in   XLEN  divisor, captured with start
//   busy       out  1     high from the edge after an accepted start through
//                         the edge on which done rises
//   done       out  1     one-cycle pulse: quo/rem/dbz/ovf carry a new result
//   quo        out  XLEN  quotient (truncated toward zero), held until next done
//   rem        out  XLEN  remainder (sign follows dividend), held until next done
//   dbz        out  1     divide-by-zero flag of the last result
//   ovf        out  1     signed overflow flag (MIN / -1) of the last result
//
// Configuration macro: DIV_FAST_SPECIAL_EN
//   defined   : b==0 and signed MIN/-1 skip CALC (done on the 2nd edge)
//   undefined : every operation takes the full XLEN+2 edges
//
// Timing: the accepting edge loads the operands, XLEN CALC edges produce one
// quotient bit each, then FIX spends two edges: the first applies sign
// correction / forced special results into the working registers, the
// second publishes them with the done pulse.
// -----------------------------------------------------------------------------
module div_unit32 #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem,
  output logic            dbz,
  output logic            ovf
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [XLEN-1:0] ZERO_V   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_V   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ONE_V    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_V    = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Two's-complement negation; -MIN wraps to MIN, which is the correct
  // unsigned magnitude of MIN.
  function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
    twos_neg = ~v + ONE_V;
  endfunction

  state_t          state_r;
  state_t          next_state_s;
  logic [CW-1:0]   count_r;
  logic [XLEN-1:0] q_r;        // quotient shift register (starts as |a|)
  logic [XLEN-1:0] r_r;        // partial remainder
  logic [XLEN-1:0] d_r;        // divisor magnitude
  logic [XLEN-1:0] a_r;        // original dividend, returned as rem on b==0
  logic            neg_q_r;
  logic            neg_r_r;
  logic            dbz_r;
  logic            ovf_r;
  logic            fix_phase_r;

  logic            load_s;
  logic            step_s;
  logic            fix0_s;
  logic            fix1_s;
  logic            b_zero_s;
  logic            min_neg1_s;
  logic            special_s;
  logic [XLEN:0]   rs_s;       // shifted remainder, XLEN+1 bits wide
  logic            ge_s;
  logic [XLEN-1:0] diff_s;
  logic [XLEN-1:0] r_next_s;
  logic [XLEN-1:0] fq_s;
  logic [XLEN-1:0] fr_s;

  assign b_zero_s   = (b == ZERO_V);
  assign min_neg1_s = is_signed & (a == MIN_V) & (b == ONES_V);
  assign special_s  = b_zero_s | min_neg1_s;

  // One restoring step. The top bit of rs_s set means rs_s >= 2^XLEN > d_r,
  // so the subtraction is taken and its true result fits in XLEN bits.
  assign rs_s   = {r_r, q_r[XLEN-1]};
  assign ge_s   = rs_s[XLEN] | (rs_s[XLEN-1:0] >= d_r);
  assign diff_s = rs_s[XLEN-1:0] - d_r;

  // Partial remainder after this iteration.
  always_comb begin
    r_next_s = rs_s[XLEN-1:0];
    if (ge_s) begin
      r_next_s = diff_s;
    end else begin
      r_next_s = rs_s[XLEN-1:0];
    end
  end

  // Final result selection: forced special values or sign-corrected Q/R.
  always_comb begin
    fq_s = q_r;
    fr_s = r_r;
    if (dbz_r) begin
      fq_s = ONES_V;
      fr_s = a_r;
    end else if (ovf_r) begin
      fq_s = MIN_V;
      fr_s = ZERO_V;
    end else begin
      if (neg_q_r) begin
        fq_s = twos_neg(q_r);
      end else begin
        fq_s = q_r;
      end
      if (neg_r_r) begin
        fr_s = twos_neg(r_r);
      end else begin
        fr_s = r_r;
      end
    end
  end

  // FSM next-state and datapath strobes.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    fix0_s       = 1'b0;
    fix1_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          load_s = 1'b1;
`ifdef DIV_FAST_SPECIAL_EN
          if (special_s) begin
            next_state_s = S_FIX;
          end else begin
            next_state_s = S_CALC;
          end
`else
          next_state_s = S_CALC;
`endif
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_CALC: begin
        step_s = 1'b1;
        if (count_r == CNT_ONE) begin
          next_state_s = S_FIX;
        end else begin
          next_state_s = S_CALC;
        end
      end
      S_FIX: begin
        if (fix_phase_r) begin
          fix1_s       = 1'b1;
          next_state_s = S_IDLE;
        end else begin
          fix0_s       = 1'b1;
          next_state_s = S_FIX;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Working registers: operand capture, iteration, and sign/special fix-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r     <= CNT_ZERO;
      q_r         <= ZERO_V;
      r_r         <= ZERO_V;
      d_r         <= ZERO_V;
      a_r         <= ZERO_V;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
      fix_phase_r <= 1'b0;
    end else if (load_s) begin
      count_r     <= CNT_INIT;
      q_r         <= (is_signed & a[XLEN-1]) ? twos_neg(a) : a;
      d_r         <= (is_signed & b[XLEN-1]) ? twos_neg(b) : b;
      r_r         <= ZERO_V;
      a_r         <= a;
      neg_q_r     <= is_signed & (a[XLEN-1] ^ b[XLEN-1]);
      neg_r_r     <= is_signed & a[XLEN-1];
      dbz_r       <= b_zero_s;
      ovf_r       <= min_neg1_s;
      fix_phase_r <= 1'b0;
    end else if (step_s) begin
      r_r     <= r_next_s;
      q_r     <= {q_r[XLEN-2:0], ge_s};
      count_r <= count_r - CNT_ONE;
    end else if (fix0_s) begin
      q_r         <= fq_s;
      r_r         <= fr_s;
      fix_phase_r <= 1'b1;
    end else if (fix1_s) begin
      fix_phase_r <= 1'b0;
    end else begin
      fix_phase_r <= fix_phase_r;
    end
  end

  // Registered outputs: busy/done handshake and the held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      quo  <= ZERO_V;
      rem  <= ZERO_V;
      dbz  <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= fix1_s;
      if (load_s) begin
        busy <= 1'b1;
      end else if (fix1_s) begin
        busy <= 1'b0;
        quo  <= q_r;
        rem  <= r_r;
        dbz  <= dbz_r;
        ovf  <= ovf_r;
      end else begin
        busy <= busy;
      end
    end
  end

endmodule

// File: tb/tb_div_unit32.sv
// -----------------------------------------------------------------------------
// tb_div_unit32 -- scoreboard bench for div_unit32. The driver pushes the
// hand-computed result and the expected done edge when start is accepted; an
// independent monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_div_unit32;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPECIAL_LAT = 2;
`else
  localparam int SPECIAL_LAT = 34;
`endif
  localparam int NORMAL_LAT = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        dbz;
  logic        ovf;

  typedef struct {
    logic [31:0] quo;
    logic [31:0] rem;
    logic        dbz;
    logic        ovf;
    int          due;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  div_unit32 #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .quo       (quo),
    .rem       (rem),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Rising-edge index, read #1 after an edge or on the falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at edge %0d expected no result pending", cyc);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_quo"}, quo, e.quo);
          check({e.name, "_rem"}, rem, e.rem);
          check({e.name, "_dbz"}, {31'd0, dbz}, {31'd0, e.dbz});
          check({e.name, "_ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
          check({e.name, "_done_edge"}, cyc, e.due);
        end
      end
    end
  end

  // Drive a request at the current time (a falling edge); it is accepted on
  // the next rising edge, where the expectation is queued.
  task automatic issue(input string nm, input logic s, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] eq,
                       input logic [31:0] er, input logic ed, input logic eo);
    exp_t e;
    bit   spec;
    spec = (bv == 32'd0) || (s && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF);
    is_signed = s;
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.quo  = eq;
    e.rem  = er;
    e.dbz  = ed;
    e.ovf  = eo;
    e.due  = cyc + (spec ? SPECIAL_LAT : NORMAL_LAT);
    e.name = nm;
    sb_q.push_back(e);
    start = 1'b0;
    // Scramble inputs: the in-flight op must not notice.
    a = $urandom;
    b = $urandom;
    is_signed = ~s;
  endtask

  // Wait (bounded) for done, counting busy cycles seen before it.
  task automatic wait_done(input string nm, input int exp_busy);
    int nb;
    bit seen;
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else if (busy === 1'b1) nb++;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: got no done in 60 cycles expected done", nm);
    end
    check({nm, "_busy_cycles"}, nb, exp_busy);
  endtask

  task automatic check_idle_zero(input string nm);
    check({nm, "_busy"}, {31'd0, busy}, 32'd0);
    check({nm, "_done"}, {31'd0, done}, 32'd0);
    check({nm, "_quo"}, quo, 32'd0);
    check({nm, "_rem"}, rem, 32'd0);
    check({nm, "_dbz"}, {31'd0, dbz}, 32'd0);
    check({nm, "_ovf"}, {31'd0, ovf}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Unsigned basic, then back-to-back start in the done cycle.
    issue("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    wait_done("u100_7", 34);
    issue("b2b_ffff_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    wait_done("b2b_ffff_1", 34);

    // Signed sign combinations.
    issue("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_done("s_m7_2", 34);
    issue("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    wait_done("s_7_m2", 34);
    issue("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0);
    wait_done("s_m100_m7", 34);

    // Divide by zero, both modes, remainder is the original dividend.
    issue("u_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
    wait_done("u_5_0", SPECIAL_LAT);
    issue("s_5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
    wait_done("s_5_0", SPECIAL_LAT);
    issue("s_m7_0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b0);
    wait_done("s_m7_0", SPECIAL_LAT);

    // MIN / -1: overflow when signed, ordinary when unsigned.
    issue("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    wait_done("s_min_m1", SPECIAL_LAT);
    issue("u_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
    wait_done("u_min_m1", 34);

    // start while busy is ignored (pulse on edge 5 after acceptance).
    issue("ign_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    is_signed = 1'b0; a = 32'd9; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ign_100_7", 29);

    // Reset mid-operation at edge 10: outputs cleared, no done afterwards.
    @(negedge clk);
    issue("rst_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    is_signed = 1'b0; a = 32'd9; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_idle_zero("mid_reset");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_reset_busy", {31'd0, busy}, 32'd0);

    issue("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);
    wait_done("u9_3", 34);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
